// File: rtl/io_button_ctrl.sv
// rtl/io_button_ctrl.sv - N-channel debounced push-button controller with edge capture and IRQ
module io_button_ctrl #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    input  logic [N_CH-1:0] button_in,
    input  logic [15:0]     io_address,
    input  logic            io_bus_enable,
    input  logic [1:0]      io_byte_enable,
    input  logic            io_rw,
    input  logic [15:0]     io_write_data,
    output logic [15:0]     io_read_data,
    output logic            io_acknowledge,
    output logic            io_irq
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [N_CH-1:0] IDLE_VEC = {N_CH{IDLE_LEVEL}};
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [N_CH-1:0] sync1, sync2, deb;
    logic [CW-1:0]   cnt [N_CH];
    logic [N_CH-1:0] flip, cap;
    logic [N_CH-1:0] edges, mask_r, sel_r;
    logic [N_CH-1:0] edges_next, mask_next, sel_next, clr;
    logic [15:0]     wm16, wdm16, rd_mux;
    logic [N_CH-1:0] wm, wdm;
    logic [2:0]      reg_sel;
    logic            accept, wr, rd;
    logic            unused_bits;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= IDLE_VEC;
            sync2 <= IDLE_VEC;
        end else begin
            sync1 <= button_in;
            sync2 <= sync1;
        end
    end

    // A flip happens on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
    always_comb begin
        flip = '0;
        cap  = '0;
        for (int i = 0; i < N_CH; i++) begin
            flip[i] = (sync2[i] != deb[i]) && (cnt[i] == CNT_LAST);
            cap[i]  = flip[i] && ((deb[i] == IDLE_LEVEL) ? !sel_r[i] : sel_r[i]);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            deb <= IDLE_VEC;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                    deb[i] <= ~deb[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (io_bus_enable) begin
                    accept     = 1'b1;
                    state_next = S_ACK;
                end
            end
            S_ACK:   state_next = S_WAIT;
            S_WAIT:  if (!io_bus_enable) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign reg_sel = io_address[3:1];
    assign wr      = accept && !io_rw;
    assign rd      = accept && io_rw;
    assign wm16    = {{8{io_byte_enable[1]}}, {8{io_byte_enable[0]}}};
    assign wdm16   = io_write_data & wm16;
    assign wm      = wm16[N_CH-1:0];
    assign wdm     = wdm16[N_CH-1:0];

    // A capture on the same edge as a W1C wins because cap is OR-ed in last.
    always_comb begin
        mask_next  = mask_r;
        sel_next   = sel_r;
        clr        = '0;
        if (wr && reg_sel == 3'd1) clr       = wdm;
        if (wr && reg_sel == 3'd2) mask_next = (mask_r & ~wm) | wdm;
        if (wr && reg_sel == 3'd3) sel_next  = (sel_r & ~wm) | wdm;
        edges_next = (edges & ~clr) | cap;
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            3'd0:    rd_mux[N_CH-1:0] = deb ^ IDLE_VEC;
            3'd1:    rd_mux[N_CH-1:0] = edges;
            3'd2:    rd_mux[N_CH-1:0] = mask_r;
            3'd3:    rd_mux[N_CH-1:0] = sel_r;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state        <= S_IDLE;
            edges        <= '0;
            mask_r       <= '0;
            sel_r        <= '0;
            io_irq       <= 1'b0;
            io_read_data <= '0;
        end else begin
            state  <= state_next;
            edges  <= edges_next;
            mask_r <= mask_next;
            sel_r  <= sel_next;
            io_irq <= |(edges_next & mask_next);
            if (accept) begin
                io_read_data <= rd ? rd_mux : 16'h0000;
            end
        end
    end

    assign io_acknowledge = (state == S_ACK);

    assign unused_bits = ^{io_address[15:4], io_address[0], wdm16};

endmodule

// File: tb/tb_io_button_ctrl.sv
// tb/tb_io_button_ctrl.sv - self-checking bench for io_button_ctrl
module tb_io_button_ctrl;
    localparam int N = 4;
    localparam int D = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  button_in      = 4'hF;
    logic [15:0] io_address     = '0;
    logic        io_bus_enable  = 1'b0;
    logic [1:0]  io_byte_enable = 2'b00;
    logic        io_rw          = 1'b1;
    logic [15:0] io_write_data  = '0;
    logic [15:0] io_read_data;
    logic        io_acknowledge;
    logic        io_irq;

    always #5 clk = ~clk;

    io_button_ctrl #(.N_CH(N), .DEBOUNCE_CYCLES(D), .IDLE_LEVEL(1'b1)) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .button_in      (button_in),
        .io_address     (io_address),
        .io_bus_enable  (io_bus_enable),
        .io_byte_enable (io_byte_enable),
        .io_rw          (io_rw),
        .io_write_data  (io_write_data),
        .io_read_data   (io_read_data),
        .io_acknowledge (io_acknowledge),
        .io_irq         (io_irq)
    );

    int tests = 0;
    int fails = 0;

    // Reference state: raw input history plus register contents
    logic [3:0]  hist [$];
    logic [3:0]  m_deb, m_edge, m_mask, m_sel;
    logic        m_irq, m_ack;
    logic [15:0] m_rd;
    int          m_bus;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;
    vec_t vt [17];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < D + 3; i++) hist.push_back(4'hF);
        m_deb  = 4'hF;
        m_edge = '0;
        m_mask = '0;
        m_sel  = '0;
        m_irq  = 1'b0;
        m_ack  = 1'b0;
        m_rd   = '0;
        m_bus  = 0;
    endfunction

    task automatic tick();
        logic [3:0]  raw_s, flip, cap, clr;
        logic        en_s, rw_s, acc;
        logic [15:0] addr_s, wm, wd;
        raw_s  = button_in;
        en_s   = io_bus_enable;
        rw_s   = io_rw;
        addr_s = io_address;
        wm     = {{8{io_byte_enable[1]}}, {8{io_byte_enable[0]}}};
        wd     = io_write_data & wm;
        @(posedge clk);
        if (!rst_n) begin
            #1;
            return;
        end
        hist.push_back(raw_s);
        void'(hist.pop_front());
        // Level flips once the synchronised input disagreed for the last D samples
        flip = 4'hF;
        for (int k = 1; k <= D; k++) flip &= hist[k] ^ m_deb;
        cap = flip & (m_deb ^ m_sel);
        acc = (m_bus == 0) && en_s;
        if (acc) m_bus = 1;
        else if (m_bus == 1) m_bus = 2;
        else if (m_bus == 2 && !en_s) m_bus = 0;
        clr = '0;
        if (acc && rw_s) begin
            case (addr_s[3:1])
                3'd0:    m_rd = {12'h000, ~m_deb};
                3'd1:    m_rd = {12'h000, m_edge};
                3'd2:    m_rd = {12'h000, m_mask};
                3'd3:    m_rd = {12'h000, m_sel};
                default: m_rd = 16'h0000;
            endcase
        end
        if (acc && !rw_s) begin
            case (addr_s[3:1])
                3'd1:    clr    = wd[3:0];
                3'd2:    m_mask = (m_mask & ~wm[3:0]) | wd[3:0];
                3'd3:    m_sel  = (m_sel & ~wm[3:0]) | wd[3:0];
                default: ;
            endcase
        end
        m_edge = (m_edge & ~clr) | cap;
        m_deb  = m_deb ^ flip;
        m_irq  = |(m_edge & m_mask);
        m_ack  = acc;
        #1;
        check("ack", 16'(io_acknowledge), 16'(m_ack));
        check("irq", 16'(io_irq), 16'(m_irq));
        if (acc && rw_s) check("rdata", io_read_data, m_rd);
    endtask

    task automatic bus(input logic rw, input logic [15:0] addr, input logic [1:0] be,
                       input logic [15:0] wd, output logic [15:0] rd, output logic irq_ack);
        io_rw          = rw;
        io_address     = addr;
        io_byte_enable = be;
        io_write_data  = wd;
        io_bus_enable  = 1'b1;
        tick();
        rd            = io_read_data;
        irq_ack       = io_irq;
        io_bus_enable = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd;
        logic        ia;
        int          lat, acks;
        int          hold [4];

        vt[0]  = '{1'b1, 16'h0000, 2'b11, 16'h0000, 16'h0000};
        vt[1]  = '{1'b1, 16'h0002, 2'b11, 16'h0000, 16'h0000};
        vt[2]  = '{1'b1, 16'h0004, 2'b11, 16'h0000, 16'h0000};
        vt[3]  = '{1'b1, 16'h0006, 2'b11, 16'h0000, 16'h0000};
        vt[4]  = '{1'b1, 16'h0008, 2'b11, 16'h0000, 16'h0000};
        vt[5]  = '{1'b0, 16'h0004, 2'b01, 16'hFF0F, 16'h0000};
        vt[6]  = '{1'b1, 16'h0004, 2'b11, 16'h0000, 16'h000F};
        vt[7]  = '{1'b0, 16'h0004, 2'b10, 16'h0000, 16'h0000};
        vt[8]  = '{1'b1, 16'h0004, 2'b11, 16'h0000, 16'h000F};
        vt[9]  = '{1'b0, 16'h0006, 2'b11, 16'h00A5, 16'h0000};
        vt[10] = '{1'b1, 16'h0006, 2'b11, 16'h0000, 16'h0005};
        vt[11] = '{1'b0, 16'h0000, 2'b11, 16'hFFFF, 16'h0000};
        vt[12] = '{1'b1, 16'h0000, 2'b11, 16'h0000, 16'h0000};
        vt[13] = '{1'b0, 16'h000E, 2'b11, 16'hFFFF, 16'h0000};
        vt[14] = '{1'b1, 16'h000E, 2'b11, 16'h0000, 16'h0000};
        vt[15] = '{1'b0, 16'h0004, 2'b11, 16'h0000, 16'h0000};
        vt[16] = '{1'b0, 16'h0006, 2'b11, 16'h0000, 16'h0000};

        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset_ack", 16'(io_acknowledge), 16'h0);
        check("reset_rdata", io_read_data, 16'h0);
        check("reset_irq", 16'(io_irq), 16'h0);

        for (int i = 0; i < 17; i++) begin
            bus(vt[i].rw, vt[i].addr, vt[i].be, vt[i].wd, rd, ia);
            if (vt[i].rw) check($sformatf("vec%0d", i), rd, vt[i].exp);
        end

        // Press ch2 with interrupts masked
        button_in = 4'b1011;
        repeat (10) tick();
        bus(1'b1, 16'h0, 2'b11, 16'h0, rd, ia);
        check("data_press2", rd, 16'h0004);
        bus(1'b1, 16'h2, 2'b11, 16'h0, rd, ia);
        check("edge_press2", rd, 16'h0004);
        check("irq_masked", 16'(io_irq), 16'h0);

        // Short glitch on ch0
        button_in[0] = 1'b0;
        repeat (3) tick();
        button_in[0] = 1'b1;
        repeat (10) tick();
        bus(1'b1, 16'h0, 2'b11, 16'h0, rd, ia);
        check("data_glitch", rd, 16'h0004);
        bus(1'b1, 16'h2, 2'b11, 16'h0, rd, ia);
        check("edge_glitch", rd, 16'h0004);

        bus(1'b0, 16'h4, 2'b11, 16'h0004, rd, ia);
        check("irq_on_mask", 16'(ia), 16'h1);
        bus(1'b0, 16'h2, 2'b11, 16'h0004, rd, ia);
        check("irq_after_w1c", 16'(ia), 16'h0);

        // Release ch2, then re-press so the capture lands on the W1C commit edge
        button_in[2] = 1'b1;
        repeat (10) tick();
        button_in[2] = 1'b0;
        repeat (5) tick();
        bus(1'b0, 16'h2, 2'b11, 16'h0004, rd, ia);
        check("irq_capture_wins", 16'(ia), 16'h1);
        bus(1'b1, 16'h2, 2'b11, 16'h0, rd, ia);
        check("edge_capture_wins", rd, 16'h0004);

        // Raw change to irq latency on ch3
        bus(1'b0, 16'h2, 2'b11, 16'h000F, rd, ia);
        bus(1'b0, 16'h4, 2'b11, 16'h0008, rd, ia);
        button_in[3] = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (io_irq) begin
                lat = c;
                break;
            end
        end
        check("press_latency", 16'(lat), 16'd6);

        // Release-select on ch1
        bus(1'b0, 16'h4, 2'b11, 16'h0000, rd, ia);
        bus(1'b0, 16'h2, 2'b11, 16'h000F, rd, ia);
        bus(1'b0, 16'h6, 2'b11, 16'h0002, rd, ia);
        button_in[1] = 1'b0;
        repeat (10) tick();
        bus(1'b1, 16'h2, 2'b11, 16'h0, rd, ia);
        check("sel_press", rd, 16'h0000);
        button_in[1] = 1'b1;
        repeat (10) tick();
        bus(1'b1, 16'h2, 2'b11, 16'h0, rd, ia);
        check("sel_release", rd, 16'h0002);

        // Request held for 5 cycles
        io_rw         = 1'b1;
        io_address    = 16'h0002;
        io_bus_enable = 1'b1;
        acks          = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (io_acknowledge) acks++;
        end
        io_bus_enable = 1'b0;
        repeat (2) tick();
        check("held_single_ack", 16'(acks), 16'd1);

        // Reset while acknowledging
        bus(1'b0, 16'h4, 2'b11, 16'h0002, rd, ia);
        io_rw         = 1'b1;
        io_address    = 16'h0004;
        io_bus_enable = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ack_reset", 16'(io_acknowledge), 16'h0);
        check("rdata_reset", io_read_data, 16'h0);
        check("irq_reset", 16'(io_irq), 16'h0);
        io_bus_enable = 1'b0;
        button_in     = 4'hF;
        repeat (2) tick();
        model_reset();
        rst_n = 1'b1;
        repeat (2) tick();
        bus(1'b1, 16'h4, 2'b11, 16'h0, rd, ia);
        check("mask_after_reset", rd, 16'h0000);

        // Randomized inputs and accesses against the reference
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    button_in[i] = 1'($urandom);
                    hold[i]      = $urandom_range(1, 8);
                end
                hold[i]--;
            end
            if ($urandom_range(0, 15) == 0) begin
                bus(1'($urandom), 16'($urandom_range(0, 7) * 2), 2'($urandom),
                    16'($urandom), rd, ia);
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_button_ctrl.md
# io_button_ctrl

Parametrised N-channel push-button controller on the external IO bus bridge (io_* interface) of the Nios system. It replaces the fixed two-input button_1/button_2 PIO pair. It synchronises and debounces up to 16 raw button inputs and captures press/release edges per channel. It raises a maskable level interrupt on io_irq and answers register accesses with the io_bus_enable/io_acknowledge handshake.

## Interface
- N_CH, 2: number of button channels, 1..16.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept a new level (1 ms at 50 MHz); must be ≥1.
- IDLE_LEVEL, 1: raw level of a released button (DE1-SoC KEYs are active-low).

Ports:
- clk_clk  in  1  system clock; the only clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- button_in  in  N_CH  raw, asynchronous button inputs.
- io_address  in  16  byte address; only bits [3:1] are decoded.
- io_bus_enable  in  1  access request; held by the master until acknowledged.
- io_byte_enable  in  2  bit [0] gates data [7:0], bit [1] gates data [15:8], writes only.
- io_rw  in  1  1 = read, 0 = write.
- io_write_data  in  16  write data.
- io_read_data  out  16  read data; valid while io_acknowledge = 1.
- io_acknowledge  out  1  one-cycle access-complete pulse.
- io_irq  out  1  level interrupt, |(EDGE & MASK), registered.

## Operation
- Synchroniser: 2-flop per channel on button_in. Both flops reset to IDLE_LEVEL.
- Debounce, per channel:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronised input equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Debounced level resets to IDLE_LEVEL.
- Edge capture:
  - A debounced flip away from IDLE_LEVEL is a press; a flip back is a release.
  - The flip sets EDGE[i] if it matches SEL[i]: 0 = press, 1 = release.
  - EDGE bits are sticky.
- Register map; unused high bits read 0 and unmapped offsets read 0x0000:
  - 0x0 DATA (RO): debounced levels, inverted when IDLE_LEVEL = 1, so 1 = pressed.
  - 0x2 EDGE (R/W1C): captured edges. Writing 1 clears the bit; writing 0 has no effect; reading does not clear.
  - 0x4 MASK (RW): interrupt enables.
  - 0x6 SEL (RW): edge select per channel.
- Writes to DATA and unmapped offsets are acknowledged and ignored. Byte enables gate which bytes of MASK, SEL and EDGE-clear take effect.
- Simultaneous capture and W1C on the same EDGE bit: the capture wins and the bit stays 1.
- Bus FSM:
  - IDLE: when io_bus_enable = 1, decode the access. A write commits at this edge; read data is registered. Go to ACK.
  - ACK: io_acknowledge = 1 for exactly this cycle, with io_read_data valid. Go to WAIT.
  - WAIT: stay until io_bus_enable = 0, then go to IDLE. A request still held after ACK is never serviced twice.
- io_irq is registered from the next-state EDGE and MASK values.

## Timing
- Reset values: io_acknowledge = 0, io_read_data = 0, io_irq = 0, EDGE = 0, MASK = 0, SEL = 0, FSM in IDLE, debounce counters 0.
- Reset asserted mid-access drops io_acknowledge immediately and returns the FSM to IDLE. An uncommitted write is lost.
- Access latency: io_bus_enable sampled high at edge T gives io_acknowledge high at T+1 and low at T+2.
  - A write's effect is visible at T+1.
  - The minimum back-to-back access period is 3 cycles: IDLE, ACK, then WAIT with bus_enable low.
- Input to DATA latency: 2 synchroniser cycles plus DEBOUNCE_CYCLES after the raw input settles.
- Glitch rejection: a raw pulse shorter than DEBOUNCE_CYCLES resets the counter and causes no flip.
- Debounce flip at edge T: EDGE set at T, io_irq high at T when MASK = 1.
- Writing MASK = 1 onto a set EDGE bit raises io_irq on the same edge as the write commit.
- The counter can never exceed DEBOUNCE_CYCLES, so there is no wrap-around.

## Test plan
Run with DEBOUNCE_CYCLES = 4, N_CH = 4, IDLE_LEVEL = 1.
- Reset release, all inputs 1 -> all outputs 0; reads of 0x0/0x2/0x4/0x6 return 0x0000 with io_acknowledge exactly 1 cycle after io_bus_enable.
- button_in[2] = 0 held for 10 cycles -> DATA = 0x0004 exactly 6 cycles after the change; EDGE = 0x0004; io_irq stays 0 (MASK = 0).
- 3-cycle low glitch on button_in[0] -> DATA and EDGE unchanged.
- Write MASK = 0x0004 with EDGE[2] already set -> io_irq = 1 at T+1. Write EDGE = 0x0004 -> io_irq = 0 the next cycle. Write EDGE = 0x0004 on the same edge as a new capture on ch2 -> EDGE[2] stays 1.
- SEL = 0x0002, press then release ch1 -> EDGE[1] set only on release.
- io_bus_enable held 5 cycles on a read -> a single ack pulse. Write 0xFF0F to MASK with byte_enable = 2'b01 -> MASK = 0x000F. Reset mid-ACK -> io_acknowledge = 0 immediately.
